// File: rtl/uart_frame_decoder_if.sv
// Purpose : groups the uart byte handshake, frame handoff and payload read port of uart_frame_decoder.
// Latency : none (wires only).
// Backpressure: rx_rdy_clr withheld while a frame is held; frame_valid/frame_ack releases it.
//
// Signals:
//   rx_data/rx_rdy/rx_rdy_clr         uart dout/rdy/rdy_clr byte handshake
//   frame_valid/frame_ack             checked frame handoff to the controller
//   frame_cmd/frame_len               header of the held frame
//   payload_addr/payload_data         payload buffer read port (1-cycle registered)
//   frame_err/err_code                error pulse and sticky error code
//   busy                              decoder is inside a frame or holding one
// Modports: master = decoder side, slave = uart/controller side.
interface uart_frame_decoder_if #(
  parameter int ADDR_W = 4
);
  logic [7:0]        rx_data;
  logic              rx_rdy;
  logic              rx_rdy_clr;
  logic              frame_valid;
  logic              frame_ack;
  logic [7:0]        frame_cmd;
  logic [7:0]        frame_len;
  logic [ADDR_W-1:0] payload_addr;
  logic [7:0]        payload_data;
  logic              frame_err;
  logic [1:0]        err_code;
  logic              busy;

  modport master (
    input  rx_data, rx_rdy, frame_ack, payload_addr,
    output rx_rdy_clr, frame_valid, frame_cmd, frame_len, payload_data,
           frame_err, err_code, busy
  );

  modport slave (
    output rx_data, rx_rdy, frame_ack, payload_addr,
    input  rx_rdy_clr, frame_valid, frame_cmd, frame_len, payload_data,
           frame_err, err_code, busy
  );
endinterface

// File: rtl/uart_frame_decoder.sv
// Purpose : assembles SOF/CMD/LEN/PAYLOAD/CHK byte frames from a uart receiver and holds a checked frame.
// Latency : frame_valid rises the cycle after the CHK byte is consumed; payload_data is 1 cycle after payload_addr.
// Backpressure: no byte is consumed while a frame is held (rx_rdy_clr stays low until frame_ack).
//
// Ports:
//   clock_50MHZ  system clock
//   reset_n      asynchronous active-low reset
//   bus          uart_frame_decoder_if.master (byte handshake, frame handoff, payload read, errors, busy)
module uart_frame_decoder #(
  parameter logic [7:0] SOF_BYTE       = 8'hAA,
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter int         ADDR_W         = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic                 clock_50MHZ,
  input  logic                 reset_n,
  uart_frame_decoder_if.master bus
);

  localparam int               PAY_DEPTH = 1 << ADDR_W;
  localparam int               CNT_W     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [7:0]       MAX_LEN8  = 8'(MAX_LEN);
  // The counter is 0 on the edge after a consumed byte, so the edge that would
  // move it to TIMEOUT_CYCLES-1 is the one that declares the timeout.
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 2);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHK,
    ST_HOLD
  } state_t;

  state_t           state_q;
  state_t           state_d;

  logic             consume;
  logic             active;
  logic             tmo_hit;
  logic             err_set;
  logic [1:0]       err_code_d;
  logic             hold_entry;

  logic             rdy_clr_q;
  logic [7:0]       cmd_q;
  logic [7:0]       len_q;
  logic [7:0]       chk_q;
  logic [7:0]       idx_q;
  logic [CNT_W-1:0] tmo_cnt_q;
  logic [7:0]       frame_cmd_q;
  logic [7:0]       frame_len_q;
  logic             frame_err_q;
  logic [1:0]       err_code_q;
  logic [7:0]       payload_data_q;

  logic [7:0]       pay_mem [PAY_DEPTH];

  // rdy_clr_q masks the cycle in which the uart has not yet dropped rdy.
  assign consume = bus.rx_rdy && !rdy_clr_q && (state_q != ST_HOLD);
  assign active  = (state_q == ST_CMD) || (state_q == ST_LEN) ||
                   (state_q == ST_PAYLOAD) || (state_q == ST_CHK);
  // A byte arriving on the timeout edge takes priority over the timeout.
  assign tmo_hit = active && !consume && (tmo_cnt_q == TMO_LAST);

  always_ff @(posedge clock_50MHZ or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    err_set    = 1'b0;
    err_code_d = 2'd0;
    hold_entry = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (consume && (bus.rx_data == SOF_BYTE)) begin
          state_d = ST_CMD;
        end
      end
      ST_CMD: begin
        if (consume) begin
          state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        if (consume) begin
          if (bus.rx_data > MAX_LEN8) begin
            err_set    = 1'b1;
            err_code_d = 2'd1;
            state_d    = ST_IDLE;
          end else if (bus.rx_data == 8'd0) begin
            state_d = ST_CHK;
          end else begin
            state_d = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (consume && (idx_q == (len_q - 8'd1))) begin
          state_d = ST_CHK;
        end
      end
      ST_CHK: begin
        if (consume) begin
          if (bus.rx_data == chk_q) begin
            hold_entry = 1'b1;
            state_d    = ST_HOLD;
          end else begin
            err_set    = 1'b1;
            err_code_d = 2'd2;
            state_d    = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        if (bus.frame_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (tmo_hit) begin
      err_set    = 1'b1;
      err_code_d = 2'd3;
      state_d    = ST_IDLE;
    end
  end

  // Frame assembly, running checksum, inter-byte timeout and output registers.
  always_ff @(posedge clock_50MHZ or negedge reset_n) begin
    if (!reset_n) begin
      rdy_clr_q   <= 1'b0;
      cmd_q       <= 8'd0;
      len_q       <= 8'd0;
      chk_q       <= 8'd0;
      idx_q       <= 8'd0;
      tmo_cnt_q   <= '0;
      frame_cmd_q <= 8'd0;
      frame_len_q <= 8'd0;
      frame_err_q <= 1'b0;
      err_code_q  <= 2'd0;
    end else begin
      rdy_clr_q   <= consume;
      frame_err_q <= err_set;

      if (err_set) begin
        err_code_q <= err_code_d;
      end

      // Header registers only change on a fully checked frame, so an aborted
      // frame never disturbs what the controller last saw.
      if (hold_entry) begin
        frame_cmd_q <= cmd_q;
        frame_len_q <= len_q;
      end

      if (consume) begin
        case (state_q)
          ST_CMD: begin
            cmd_q <= bus.rx_data;
            chk_q <= bus.rx_data;
          end
          ST_LEN: begin
            len_q <= bus.rx_data;
            chk_q <= chk_q ^ bus.rx_data;
            idx_q <= 8'd0;
          end
          ST_PAYLOAD: begin
            chk_q <= chk_q ^ bus.rx_data;
            idx_q <= idx_q + 8'd1;
          end
          default: begin
          end
        endcase
      end

      if (!active || consume || tmo_hit) begin
        tmo_cnt_q <= '0;
      end else begin
        tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
      end
    end
  end

  // Payload storage has no reset; only bytes below frame_len are meaningful.
  always_ff @(posedge clock_50MHZ) begin
    if (consume && (state_q == ST_PAYLOAD)) begin
      pay_mem[idx_q[ADDR_W-1:0]] <= bus.rx_data;
    end
  end

  always_ff @(posedge clock_50MHZ or negedge reset_n) begin
    if (!reset_n) begin
      payload_data_q <= 8'd0;
    end else begin
      payload_data_q <= pay_mem[bus.payload_addr];
    end
  end

  assign bus.rx_rdy_clr   = rdy_clr_q;
  assign bus.frame_valid  = (state_q == ST_HOLD);
  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.frame_cmd    = frame_cmd_q;
  assign bus.frame_len    = frame_len_q;
  assign bus.frame_err    = frame_err_q;
  assign bus.err_code     = err_code_q;
  assign bus.payload_data = payload_data_q;

endmodule

// File: tb/tb_uart_frame_decoder.sv
module tb_uart_frame_decoder;

  localparam int MAX_LEN = 16;
  localparam int ADDR_W  = 4;
  localparam int TMO     = 100;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  uart_frame_decoder_if #(.ADDR_W(ADDR_W)) bus ();

  uart_frame_decoder #(
    .SOF_BYTE      (8'hAA),
    .MAX_LEN       (MAX_LEN),
    .TIMEOUT_CYCLES(TMO),
    .ADDR_W        (ADDR_W)
  ) dut (
    .clock_50MHZ(clk),
    .reset_n    (rst_n),
    .bus        (bus)
  );

  typedef struct packed {
    logic [7:0]      cmd;
    logic [7:0]      len;
    logic [2:0][7:0] pay;
  } frame_t;

  frame_t     exp_frames[$];
  int         exp_errs[$];

  int         checks   = 0;
  int         failures = 0;

  int         cyc         = 0;
  int         clr_cnt     = 0;
  int         err_cnt     = 0;
  int         consume_cyc = 0;
  int         err_cyc     = 0;
  logic [1:0] last_err_code = 2'd0;
  int         err_seen    = 0;
  logic [7:0] last_cmd    = 8'd0;
  logic [7:0] last_len    = 8'd0;

  always @(posedge clk) cyc = cyc + 1;

  // Passive monitor: records every rx_rdy_clr pulse and error pulse with the
  // index of the edge that produced it.
  always @(negedge clk) begin
    if (bus.rx_rdy_clr === 1'b1) begin
      clr_cnt++;
      consume_cyc = cyc;
    end
    if (bus.frame_err === 1'b1) begin
      err_cnt++;
      err_cyc       = cyc;
      last_err_code = bus.err_code;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Uart model: present a byte, wait for rdy_clr, drop rdy on the edge that samples it.
  task automatic send_byte(input logic [7:0] b);
    bit got;
    got = 1'b0;
    bus.rx_data = b;
    bus.rx_rdy  = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.rx_rdy_clr === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    check("byte_consumed", 32'(got), 32'd1);
    tick();
    bus.rx_rdy = 1'b0;
  endtask

  task automatic push_frame(input logic [7:0] cmd, input logic [7:0] len,
                            input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2);
    frame_t f;
    f.cmd    = cmd;
    f.len    = len;
    f.pay[0] = p0;
    f.pay[1] = p1;
    f.pay[2] = p2;
    exp_frames.push_back(f);
  endtask

  task automatic send_frame(input logic [7:0] cmd, input int len,
                            input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2);
    logic [7:0] chk;
    logic [7:0] p [3];
    p[0] = p0;
    p[1] = p1;
    p[2] = p2;
    chk  = cmd ^ 8'(len);
    for (int i = 0; i < len; i++) chk = chk ^ p[i];
    push_frame(cmd, 8'(len), p0, p1, p2);
    send_byte(8'hAA);
    send_byte(cmd);
    send_byte(8'(len));
    for (int i = 0; i < len; i++) send_byte(p[i]);
    send_byte(chk);
  endtask

  task automatic check_frame();
    bit     ok;
    frame_t f;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (bus.frame_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("frame_valid_rise", 32'(ok), 32'd1);
    check("frame_expected", 32'(exp_frames.size() > 0), 32'd1);
    if (exp_frames.size() > 0) begin
      f = exp_frames.pop_front();
      check("frame_cmd", 32'(bus.frame_cmd), 32'(f.cmd));
      check("frame_len", 32'(bus.frame_len), 32'(f.len));
      for (int i = 0; i < int'(f.len); i++) begin
        bus.payload_addr = i[ADDR_W-1:0];
        tick();
        check("payload_data", 32'(bus.payload_data), 32'(f.pay[i]));
      end
      last_cmd = f.cmd;
      last_len = f.len;
    end
    check("no_err_pulse", err_cnt, err_seen);
  endtask

  task automatic ack_frame();
    bus.frame_ack = 1'b1;
    tick();
    bus.frame_ack = 1'b0;
    check("valid_drop_after_ack", 32'(bus.frame_valid), 32'd0);
    check("idle_after_ack", 32'(bus.busy), 32'd0);
    check("cmd_stable_after_ack", 32'(bus.frame_cmd), 32'(last_cmd));
  endtask

  task automatic expect_err();
    bit ok;
    int code;
    ok   = 1'b0;
    code = 0;
    for (int i = 0; i < 300; i++) begin
      if (err_cnt > err_seen) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("err_pulse_seen", 32'(ok), 32'd1);
    if (exp_errs.size() > 0) code = exp_errs.pop_front();
    repeat (3) tick();
    check("err_code_at_pulse", 32'(last_err_code), code);
    check("err_code_held", 32'(bus.err_code), code);
    check("err_single_pulse", err_cnt, err_seen + 1);
    check("err_no_valid", 32'(bus.frame_valid), 32'd0);
    check("err_idle", 32'(bus.busy), 32'd0);
    check("err_keeps_cmd", 32'(bus.frame_cmd), 32'(last_cmd));
    check("err_keeps_len", 32'(bus.frame_len), 32'(last_len));
    err_seen = err_cnt;
  endtask

  initial begin
    int base_clr;
    int c0;
    int ack_cyc;

    bus.rx_data      = 8'h00;
    bus.rx_rdy       = 1'b0;
    bus.frame_ack    = 1'b0;
    bus.payload_addr = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(bus.frame_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_rdy_clr", 32'(bus.rx_rdy_clr), 32'd0);
    check("rst_err", 32'(bus.frame_err), 32'd0);
    check("rst_cmd", 32'(bus.frame_cmd), 32'd0);
    check("rst_len", 32'(bus.frame_len), 32'd0);
    check("rst_code", 32'(bus.err_code), 32'd0);
    check("rst_pdata", 32'(bus.payload_data), 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic frame AA 01 02 10 20 33
    base_clr = clr_cnt;
    send_frame(8'h01, 2, 8'h10, 8'h20, 8'h00);
    check_frame();
    ack_frame();
    check("six_clr_pulses", clr_cnt - base_clr, 6);

    // Zero-length frame, then a junk byte dropped in IDLE, then another frame
    send_frame(8'h05, 0, 8'h00, 8'h00, 8'h00);
    check_frame();
    ack_frame();
    send_byte(8'h55);
    check("junk_dropped_idle", 32'(bus.busy), 32'd0);
    send_frame(8'h07, 0, 8'h00, 8'h00, 8'h00);
    check_frame();
    ack_frame();

    // Checksum mismatch
    exp_errs.push_back(2);
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h02);
    send_byte(8'h10); send_byte(8'h20); send_byte(8'h34);
    expect_err();

    // LEN one above MAX_LEN, error on the LEN byte itself
    exp_errs.push_back(1);
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h11);
    check("len_err_on_len_edge", err_cyc, consume_cyc);
    expect_err();

    // Inter-byte timeout
    exp_errs.push_back(3);
    send_byte(8'hAA); send_byte(8'h01);
    c0 = consume_cyc;
    expect_err();
    check("timeout_distance", err_cyc - c0, 99);

    // Byte landing exactly on the timeout edge wins
    send_byte(8'hAA); send_byte(8'h01);
    c0 = consume_cyc;
    while (cyc < c0 + 98) tick();
    push_frame(8'h01, 8'h01, 8'h5A, 8'h00, 8'h00);
    send_byte(8'h01);
    check("late_byte_edge", consume_cyc - c0, 99);
    check("late_byte_no_err", err_cnt, err_seen);
    send_byte(8'h5A);
    send_byte(8'h5A);
    check_frame();
    ack_frame();

    // Backpressure while holding a frame
    send_frame(8'h03, 1, 8'h44, 8'h00, 8'h00);
    check_frame();
    bus.rx_data = 8'hAA;
    bus.rx_rdy  = 1'b1;
    base_clr    = clr_cnt;
    repeat (20) tick();
    check("hold_no_consume", clr_cnt, base_clr);
    check("hold_valid_kept", 32'(bus.frame_valid), 32'd1);
    check("hold_cmd_stable", 32'(bus.frame_cmd), 32'h03);
    bus.frame_ack = 1'b1;
    tick();
    bus.frame_ack = 1'b0;
    ack_cyc = cyc;
    push_frame(8'h09, 8'h00, 8'h00, 8'h00, 8'h00);
    send_byte(8'hAA);
    check("held_byte_after_ack", consume_cyc, ack_cyc + 1);
    send_byte(8'h09); send_byte(8'h00); send_byte(8'h09);
    check_frame();
    ack_frame();

    // Reset in the middle of a payload
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h03); send_byte(8'h11);
    check("busy_in_payload", 32'(bus.busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_valid", 32'(bus.frame_valid), 32'd0);
    check("mrst_busy", 32'(bus.busy), 32'd0);
    check("mrst_rdy_clr", 32'(bus.rx_rdy_clr), 32'd0);
    check("mrst_err", 32'(bus.frame_err), 32'd0);
    check("mrst_cmd", 32'(bus.frame_cmd), 32'd0);
    check("mrst_len", 32'(bus.frame_len), 32'd0);
    check("mrst_code", 32'(bus.err_code), 32'd0);
    check("mrst_pdata", 32'(bus.payload_data), 32'd0);
    last_cmd = 8'h00;
    last_len = 8'h00;
    tick();
    rst_n = 1'b1;
    tick();

    // Full frame after reset, with the SOF value appearing as payload
    send_frame(8'h0B, 2, 8'hAA, 8'h55, 8'h00);
    check_frame();
    ack_frame();

    check("frames_all_seen", exp_frames.size(), 0);
    check("errs_all_seen", exp_errs.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
